noise_generator: RTL and testbench
==================================

# noise_generator

Pseudo-random noise source for the digital synthesizer. It produces a 12-bit two's-complement white-noise sample every clock from a 32-bit Galois LFSR, with programmable seed and power-of-two attenuation. It is the producer side of the noise path: its `DATA_FROM_NOISE` output drives the downstream noise delay buffer directly, one sample per clock while `NOISE_VALID` is high.

## Interface
- `DATA_WIDTH`, 12: output sample width.
- `LFSR_WIDTH`, 32: LFSR state width.
- `DEFAULT_SEED`, 32'hACE1_2468: seed used after reset and for a zero seed load.
- `TAPS`, 32'h8020_0003: Galois right-shift feedback mask (x^32+x^22+x^2+x+1).
- `WARMUP_CYCLES`, 16: LFSR advances discarded after START.
- `CLK` in 1: clock.
- `RESET` in 1: reset, synchronous, active-high; clock CLK.
- `START` in 1: one-cycle pulse that begins generation.
- `STOP` in 1: one-cycle pulse that ends generation.
- `SEED_LOAD` in 1: loads `SEED` into the LFSR.
- `SEED` in 32: seed value.
- `ATTEN` in 4: arithmetic right-shift amount applied to the sample.
- `DATA_FROM_NOISE` out 12: noise sample, signed.
- `NOISE_VALID` out 1: sample on `DATA_FROM_NOISE` is valid this cycle.
- `BUSY` out 1: high in WARMUP or RUN.

## Operation
- **States:** IDLE, WARMUP, RUN.
- **Reset values:** state = IDLE, LFSR = `DEFAULT_SEED`, warm-up counter = 0, `DATA_FROM_NOISE` = 0, `NOISE_VALID` = 0, `BUSY` = 0. Outputs are never high-Z.
- **LFSR step:** if lfsr[0] = 1, lfsr ← (lfsr >> 1) ^ `TAPS`; otherwise lfsr ← lfsr >> 1.
- **IDLE:**
  - The LFSR holds its value.
  - `SEED_LOAD` = 1 loads `SEED`. A `SEED` of 0 loads `DEFAULT_SEED` instead, so the all-zero lock-up state is impossible.
  - `START` = 1 moves the block to WARMUP and clears the counter.
- **WARMUP:**
  - The LFSR advances every cycle and the counter increments.
  - When the counter reaches `WARMUP_CYCLES`-1, the block moves to RUN.
  - `NOISE_VALID` stays 0.
- **RUN:**
  - The LFSR advances every cycle.
  - Output register ← sign-preserving arithmetic right shift of lfsr[11:0] (interpreted signed) by min(`ATTEN`, 11).
  - `NOISE_VALID` ← 1.
- **STOP:** `STOP` = 1 in WARMUP or RUN returns the block to IDLE. On the next edge `NOISE_VALID` ← 0 and `DATA_FROM_NOISE` ← 0. The LFSR keeps its current value, so a restart continues the sequence.
- **Ignored inputs:**
  - `SEED_LOAD` outside IDLE.
  - `START` outside IDLE.
  - `STOP` in IDLE.
- **Simultaneous events:**
  - `START` and `STOP` in the same cycle: `STOP` wins, and the block stays in or returns to IDLE.
  - `SEED_LOAD` and `START` in IDLE: the seed loads and the block enters WARMUP. Warm-up starts from the new seed.
- **ATTEN:** sampled every cycle, so a change affects the next output sample. Values 12–15 saturate to 11, giving outputs of 0x000 or 0xFFF only.
- **RESET:** has priority over everything. Mid-RUN it forces all reset values on the next edge.

## Timing
- `START` sampled at edge 0 → `BUSY` = 1 after edge 0.
- Warm-up covers edges 1–16; RUN is entered at edge 16; the first `NOISE_VALID` = 1 appears after edge 17.
- Latency from an LFSR state to its output sample is one cycle (registered output).
- Throughput is one sample per clock in RUN, with no gaps.
- `STOP` at edge n → `NOISE_VALID` = 0 and `BUSY` = 0 after edge n.
- `DATA_FROM_NOISE` is meaningful only while `NOISE_VALID` = 1, and is 0 otherwise.

## Structure
- **`noise_pkg`:** state enum (IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2), `DEFAULT_SEED`, `TAPS`, `WARMUP_CYCLES`, and the `ATTEN` saturation constant 11.
- **Sub-module `lfsr_core`:** the 32-bit Galois register with load (zero-seed substitution) and advance enable. The FSM, warm-up counter and attenuation/output register stay in `noise_generator`.

## Test plan
- **Reset:** assert `RESET` during RUN → after one edge, `DATA_FROM_NOISE` = 0, `NOISE_VALID` = 0, `BUSY` = 0, LFSR = 32'hACE1_2468.
- **Seed and warm-up:** `SEED_LOAD` with `SEED` = 32'h0000_0001, then `START` → first LFSR step gives 32'h8020_0003. `NOISE_VALID` rises exactly 17 edges after `START`. The first 64 samples match a bit-exact reference model.
- **Zero seed:** `SEED_LOAD` with `SEED` = 0 → LFSR = 32'hACE1_2468. The output sequence is identical to the post-reset sequence.
- **Attenuation:** `ATTEN` = 15 in RUN → every valid sample is 0x000 or 0xFFF. `ATTEN` = 0 → the output equals lfsr[11:0] from the previous cycle.
- **Start/stop:** `START` and `STOP` in the same cycle from IDLE → `BUSY` stays 0. `STOP` mid-RUN followed by `START` → the sequence resumes from the held LFSR state after 16 further warm-up steps.
- **Ignored inputs:** `SEED_LOAD` during RUN → no discontinuity versus the model.

Source files
------------

// File: rtl/noise_generator_pkg.sv
// ---------------------------------------------------------------------------
// noise_pkg
// Shared constants, the controller state type and the LFSR step function for
// the noise source.
//   DATA_WIDTH     : width of the signed noise sample
//   LFSR_WIDTH     : width of the Galois LFSR state
//   DEFAULT_SEED   : state after reset and substitute for a zero seed
//   TAPS           : Galois right-shift feedback mask (x^32+x^22+x^2+x+1)
//   WARMUP_CYCLES  : LFSR advances thrown away after START
//   ATTEN_MAX      : largest useful attenuation shift (sample width - 1)
// ---------------------------------------------------------------------------
package noise_pkg;

  localparam int DATA_WIDTH     = 12;
  localparam int LFSR_WIDTH     = 32;
  localparam int WARMUP_CYCLES  = 16;
  localparam int WARM_CNT_WIDTH = $clog2(WARMUP_CYCLES);

  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 32'hACE1_2468;
  localparam logic [LFSR_WIDTH-1:0] TAPS         = 32'h8020_0003;

  // Shifting a 12-bit signed value by 11 already leaves only the sign, so
  // anything larger is clamped here.
  localparam logic [3:0] ATTEN_MAX = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } noise_state_t;

  // One Galois step: shift right, and fold the taps in when a 1 falls out.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/noise_generator_if.sv
// ---------------------------------------------------------------------------
// noise_generator_if
// Control and data bundle of the noise source.
//   START, STOP      : one-cycle pulses to begin / end generation
//   SEED_LOAD, SEED  : seed load request and value (honoured only when idle)
//   ATTEN            : arithmetic right-shift applied to each sample
//   DATA_FROM_NOISE  : signed noise sample, zero whenever not valid
//   NOISE_VALID      : DATA_FROM_NOISE carries a sample this cycle
//   BUSY             : generator is warming up or running
// master = controller / consumer side, slave = noise_generator.
// ---------------------------------------------------------------------------
interface noise_generator_if;
  import noise_pkg::*;

  logic                  START;
  logic                  STOP;
  logic                  SEED_LOAD;
  logic [LFSR_WIDTH-1:0] SEED;
  logic [3:0]            ATTEN;
  logic [DATA_WIDTH-1:0] DATA_FROM_NOISE;
  logic                  NOISE_VALID;
  logic                  BUSY;

  modport master (
    output START, STOP, SEED_LOAD, SEED, ATTEN,
    input  DATA_FROM_NOISE, NOISE_VALID, BUSY
  );

  modport slave (
    input  START, STOP, SEED_LOAD, SEED, ATTEN,
    output DATA_FROM_NOISE, NOISE_VALID, BUSY
  );

endinterface

// File: rtl/noise_generator_lfsr_core.sv
// ---------------------------------------------------------------------------
// lfsr_core
// 32-bit Galois LFSR with seed load and advance enable.
//   CLK, RESET : clock, synchronous active-high reset (state -> DEFAULT_SEED)
//   load       : take seed this cycle (a zero seed becomes DEFAULT_SEED)
//   seed       : seed value
//   advance    : step the register this cycle
//   sample     : low DATA_WIDTH bits of the current state
// ---------------------------------------------------------------------------
module lfsr_core
  import noise_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] sample
);

  logic [LFSR_WIDTH-1:0] state_q;

  // Load has priority over advance; the controller never asks for both, but
  // a zero seed must never reach the register or the sequence locks up.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= DEFAULT_SEED;
    end else if (load) begin
      state_q <= (seed == '0) ? DEFAULT_SEED : seed;
    end else if (advance) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign sample = state_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/noise_generator.sv
// ---------------------------------------------------------------------------
// noise_generator
// White-noise source: START runs the LFSR through a warm-up, then emits one
// attenuated 12-bit signed sample per clock until STOP.
//   CLK   : clock
//   RESET : synchronous active-high reset
//   bus   : noise_generator_if.slave (START/STOP/SEED_LOAD/SEED/ATTEN in,
//           DATA_FROM_NOISE/NOISE_VALID/BUSY out, all outputs registered)
// ---------------------------------------------------------------------------
module noise_generator
  import noise_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  noise_generator_if.slave    bus
);

  noise_state_t                state;
  logic [WARM_CNT_WIDTH-1:0]   warm_cnt;
  logic [DATA_WIDTH-1:0]       data_q;
  logic                        valid_q;
  logic                        busy_q;

  logic                        lfsr_load;
  logic                        lfsr_advance;
  logic [DATA_WIDTH-1:0]       lfsr_sample;
  logic [3:0]                  shift_amt;
  logic signed [DATA_WIDTH-1:0] atten_sample;

  // Seeds are only accepted while idle. The LFSR steps in WARMUP and RUN,
  // but not on the STOP edge, so a later restart picks up where it left off.
  assign lfsr_load    = (state == IDLE) && bus.SEED_LOAD;
  assign lfsr_advance = (state != IDLE) && !bus.STOP;

  lfsr_core u_lfsr (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (lfsr_load),
    .seed    (bus.SEED),
    .advance (lfsr_advance),
    .sample  (lfsr_sample)
  );

  assign shift_amt    = (bus.ATTEN > ATTEN_MAX) ? ATTEN_MAX : bus.ATTEN;
  assign atten_sample = $signed(lfsr_sample) >>> shift_amt;

  // Controller: IDLE -> WARMUP on START, WARMUP -> RUN after the last
  // warm-up step, STOP from either active state back to IDLE. STOP beats a
  // simultaneous START. Outputs are registered and cleared outside RUN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      warm_cnt <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_q  <= '0;
          valid_q <= 1'b0;
          if (bus.START && !bus.STOP) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            busy_q   <= 1'b1;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        WARMUP: begin
          data_q  <= '0;
          valid_q <= 1'b0;
          if (bus.STOP) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
            busy_q   <= 1'b1;
            if (warm_cnt == WARM_CNT_WIDTH'(WARMUP_CYCLES - 1)) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.STOP) begin
            state   <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            data_q  <= atten_sample;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          data_q  <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DATA_FROM_NOISE = data_q;
  assign bus.NOISE_VALID     = valid_q;
  assign bus.BUSY            = busy_q;

endmodule

// File: tb/tb_noise_generator.sv
// ---------------------------------------------------------------------------
// tb_noise_generator
// Self-checking bench for noise_generator: a vector table for reset, idle
// and start/stop corner cases, hand sequences for warm-up latency, reset in
// RUN, zero seed, attenuation and restart, then randomized traffic checked
// against a behavioural model of the noise source.
// ---------------------------------------------------------------------------
module tb_noise_generator;

  localparam logic [31:0] REF_SEED = 32'hACE1_2468;
  localparam logic [31:0] REF_TAPS = 32'h8020_0003;
  localparam int          REF_WARM = 16;

  logic CLK;
  logic RESET;

  noise_generator_if bus ();

  noise_generator dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total;
  int bad;

  // Behavioural model: mode 0 idle, 1 warming, 2 running; warm_left counts
  // the warm-up steps still to go.
  logic [31:0] m_lfsr;
  int          m_mode;
  int          m_left;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_busy;

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];

  typedef struct {
    string       name;
    bit          rst;
    bit          st;
    bit          sp;
    bit          sl;
    logic [31:0] seed;
    logic [3:0]  atten;
    logic [11:0] exp_data;
    bit          exp_valid;
    bit          exp_busy;
    logic [31:0] exp_lfsr;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    if (s % 2 == 1) return (s / 2) ^ REF_TAPS;
    return s / 2;
  endfunction

  // Signed floor division by 2^shift, which is what an arithmetic shift does.
  function automatic logic [11:0] ref_atten(input logic [31:0] s, input int atten);
    int v;
    int sh;
    int dv;
    int q;
    v = int'(s % 4096);
    if (v >= 2048) v = v - 4096;
    sh = (atten > 11) ? 11 : atten;
    dv = 1 << sh;
    if (v >= 0) q = v / dv;
    else q = -((-v + dv - 1) / dv);
    return q[11:0];
  endfunction

  task automatic modelEdge(input bit rst, input bit st, input bit sp, input bit sl,
                           input logic [31:0] seed, input logic [3:0] atten);
    if (rst) begin
      m_lfsr = REF_SEED; m_mode = 0; m_left = 0;
      m_data = 0; m_valid = 0; m_busy = 0;
    end else if (m_mode == 0) begin
      if (sl) m_lfsr = (seed == 0) ? REF_SEED : seed;
      if (st && !sp) begin
        m_mode = 1; m_left = REF_WARM;
      end
      m_data = 0; m_valid = 0; m_busy = (m_mode != 0);
    end else if (sp) begin
      m_mode = 0; m_data = 0; m_valid = 0; m_busy = 0;
    end else if (m_mode == 1) begin
      m_lfsr = ref_step(m_lfsr);
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 2;
      m_data = 0; m_valid = 0; m_busy = 1;
    end else begin
      m_data = ref_atten(m_lfsr, int'(atten));
      m_valid = 1; m_busy = 1;
      m_lfsr = ref_step(m_lfsr);
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, let the model see the same rising
  // edge as the DUT, then settle 1 unit before anyone samples outputs.
  task automatic applyStimulus(input bit rst, input bit st, input bit sp, input bit sl,
                               input logic [31:0] seed, input logic [3:0] atten);
    @(negedge CLK);
    RESET = rst; bus.START = st; bus.STOP = sp; bus.SEED_LOAD = sl;
    bus.SEED = seed; bus.ATTEN = atten;
    @(posedge CLK);
    modelEdge(rst, st, sp, sl, seed, atten);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] exp_data,
                             input bit exp_valid, input bit exp_busy);
    cmp({name, ".data"},  32'(bus.DATA_FROM_NOISE), 32'(exp_data));
    cmp({name, ".valid"}, 32'(bus.NOISE_VALID),     32'(exp_valid));
    cmp({name, ".busy"},  32'(bus.BUSY),            32'(exp_busy));
  endtask

  task automatic stepModel(input string name, input bit rst, input bit st, input bit sp,
                           input bit sl, input logic [31:0] seed, input logic [3:0] atten);
    applyStimulus(rst, st, sp, sl, seed, atten);
    checkOutput(name, m_data, m_valid, m_busy);
  endtask

  // Start from IDLE and gather the first 40 valid samples at ATTEN = 0.
  task automatic runAndCollect(input int which);
    int got;
    got = 0;
    stepModel("collect_start", 0, 1, 0, 0, 32'h0, 4'd0);
    for (int i = 0; i < 80 && got < 40; i++) begin
      stepModel("collect", 0, 0, 0, 0, 32'h0, 4'd0);
      if (bus.NOISE_VALID) begin
        if (which == 0) q_a.push_back(bus.DATA_FROM_NOISE);
        else q_b.push_back(bus.DATA_FROM_NOISE);
        got++;
      end
    end
    cmp("collect_count", 32'(got), 32'd40);
  endtask

  // Hard stop in case anything above waits forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] prev_lfsr;
    bit          rst;
    bit          st;
    bit          sp;
    bit          sl;
    logic [31:0] seed;
    logic [3:0]  at;

    total = 0;
    bad   = 0;
    RESET = 1'b1;
    bus.START = 1'b0; bus.STOP = 1'b0; bus.SEED_LOAD = 1'b0;
    bus.SEED = '0; bus.ATTEN = '0;

    vecs[0]  = '{"reset",        1, 0, 0, 0, 32'h0,    4'd0, 12'h0, 0, 0, 32'hACE1_2468};
    vecs[1]  = '{"idle_hold",    0, 0, 0, 0, 32'h0,    4'd0, 12'h0, 0, 0, 32'hACE1_2468};
    vecs[2]  = '{"stop_in_idle", 0, 0, 1, 0, 32'h0,    4'd0, 12'h0, 0, 0, 32'hACE1_2468};
    vecs[3]  = '{"start_stop",   0, 1, 1, 0, 32'h0,    4'd0, 12'h0, 0, 0, 32'hACE1_2468};
    vecs[4]  = '{"seed_one",     0, 0, 0, 1, 32'h1,    4'd0, 12'h0, 0, 0, 32'h0000_0001};
    vecs[5]  = '{"start",        0, 1, 0, 0, 32'h0,    4'd0, 12'h0, 0, 1, 32'h0000_0001};
    vecs[6]  = '{"warm_step1",   0, 0, 0, 0, 32'h0,    4'd0, 12'h0, 0, 1, 32'h8020_0003};
    vecs[7]  = '{"seed_in_warm", 0, 0, 0, 1, 32'h1234, 4'd0, 12'h0, 0, 1, 32'hC030_0002};
    vecs[8]  = '{"stop_warm",    0, 0, 1, 0, 32'h0,    4'd0, 12'h0, 0, 0, 32'hC030_0002};
    vecs[9]  = '{"seed_zero",    0, 0, 0, 1, 32'h0,    4'd0, 12'h0, 0, 0, 32'hACE1_2468};
    vecs[10] = '{"reset_start",  1, 1, 0, 0, 32'h0,    4'd0, 12'h0, 0, 0, 32'hACE1_2468};

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].sl, vecs[i].seed, vecs[i].atten);
      checkOutput(vecs[i].name, vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_busy);
      cmp({vecs[i].name, ".lfsr"}, dut.u_lfsr.state_q, vecs[i].exp_lfsr);
    end

    // Seed 1, warm-up latency and the first 64 raw samples.
    $display("[TB] seed one, warm-up latency, raw samples");
    stepModel("seed1_load", 0, 0, 0, 1, 32'h1, 4'd0);
    stepModel("seed1_start", 0, 1, 0, 0, 32'h0, 4'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      stepModel("warmup", 0, 0, 0, 0, 32'h0, 4'd0);
      n++;
      if (n == 1) cmp("first_step", dut.u_lfsr.state_q, 32'h8020_0003);
      if (bus.NOISE_VALID) break;
    end
    cmp("valid_latency", 32'(n), 32'd17);
    for (int i = 0; i < 63; i++) begin
      prev_lfsr = m_lfsr;
      stepModel("raw_sample", 0, 0, 0, 0, 32'h0, 4'd0);
      cmp("atten0_raw", 32'(bus.DATA_FROM_NOISE), 32'(prev_lfsr[11:0]));
    end

    // Stop mid-run, idle a while, restart: the model holds its state.
    $display("[TB] stop and resume");
    stepModel("stop_run", 0, 0, 1, 0, 32'h0, 4'd0);
    for (int i = 0; i < 4; i++) stepModel("stopped", 0, 0, 0, 0, 32'h0, 4'd3);
    stepModel("restart", 0, 1, 0, 0, 32'h0, 4'd0);
    for (int i = 0; i < 24; i++) stepModel("resume", 0, 0, 0, 0, 32'h0, 4'(i % 16));

    // Reset while running.
    $display("[TB] reset in run");
    applyStimulus(1, 0, 0, 0, 32'h0, 4'd0);
    checkOutput("reset_run", 12'h000, 1'b0, 1'b0);
    cmp("reset_run.lfsr", dut.u_lfsr.state_q, 32'hACE1_2468);

    // Post-reset sequence versus zero-seed sequence.
    $display("[TB] zero seed");
    runAndCollect(0);
    stepModel("zs_stop", 0, 0, 1, 0, 32'h0, 4'd0);
    stepModel("zs_load", 0, 0, 0, 1, 32'h0, 4'd0);
    runAndCollect(1);
    for (int i = 0; i < 40; i++) begin
      cmp("zero_seed_seq", 32'(q_b[i]), 32'(q_a[i]));
    end

    // Full attenuation: only the sign survives.
    $display("[TB] attenuation 15");
    for (int i = 0; i < 30; i++) begin
      stepModel("atten15", 0, 0, 0, 0, 32'h0, 4'd15);
      cmp("atten15_sign", 32'(bus.DATA_FROM_NOISE == 12'h000 || bus.DATA_FROM_NOISE == 12'hFFF), 32'd1);
    end

    // Seed loads while running must not disturb the sequence.
    $display("[TB] seed load in run");
    for (int i = 0; i < 10; i++) stepModel("seed_in_run", 0, 0, 0, 1, $urandom, 4'd2);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      st   = ($urandom_range(0, 15) == 0);
      sp   = ($urandom_range(0, 59) == 0);
      sl   = ($urandom_range(0, 9) == 0);
      seed = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      at   = 4'($urandom_range(0, 15));
      stepModel("random", rst, st, sp, sl, seed, at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
